// File: rtl/xgmii_tx_fifo_reader.sv
// xgmii_tx_fifo_reader
// Drains the 36-bit TX word FIFO (registered read data) onto the 32-bit
// XGMII TX interface. Idles are sent between frames. Output is aligned to
// the frame start word. A minimum inter-packet gap of IPG_WORDS idle words
// follows each terminate. If the FIFO underruns mid-frame, the frame is
// aborted with an ERROR word and the rest of the frame is discarded.
//
// FIFO word: [35:32] = txc lanes 3..0, [31:0] = txd (lane 0 = [7:0] / bit 32).
//
// Parameters:
//   IPG_WORDS     minimum idle words between terminate and next start (>= 1)
//
// Ports:
//   clk, rst      clock; asynchronous active-low reset
//   tx_enable     permits starting a new frame (sampled in IDLE only)
//   fifo_empty    FIFO empty flag
//   fifo_rd_en    FIFO read request (combinational)
//   fifo_rd_data  FIFO read data, valid the cycle after an accepted read
//   xgmii_txd     XGMII data (registered)
//   xgmii_txc     XGMII control (registered)
//   busy          high whenever the reader is not in IDLE
//   underrun_err  one-cycle pulse on underrun abort
//   bad_start_err one-cycle pulse when a non-start word is dropped in IDLE
//
// Optional build macro XGMII_TX_STATS_EN adds two ports:
//   frame_count    32-bit wrapping count of emitted start words
//   underrun_count 16-bit count of underrun aborts, saturating at 0xFFFF
`timescale 1ns/1ps

module xgmii_tx_fifo_reader #(
  parameter int unsigned IPG_WORDS = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tx_enable,
  input  logic        fifo_empty,
  output logic        fifo_rd_en,
  input  logic [35:0] fifo_rd_data,
  output logic [31:0] xgmii_txd,
  output logic [3:0]  xgmii_txc,
  output logic        busy,
  output logic        underrun_err,
  output logic        bad_start_err
`ifdef XGMII_TX_STATS_EN
  ,
  output logic [31:0] frame_count,
  output logic [15:0] underrun_count
`endif
);

  localparam logic [31:0] IDLE_TXD = 32'h0707_0707;
  localparam logic [31:0] ERR_TXD  = 32'hFEFE_FEFE;
  // Counter holds IPG_WORDS-2 at most.
  localparam int unsigned CW = (IPG_WORDS > 2) ? $clog2(IPG_WORDS - 1) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_DISCARD,
    ST_IPG
  } state_t;

  state_t          state_q, state_d;
  logic            p_q, p_d;
  logic [CW-1:0]   ipg_cnt_q, ipg_cnt_d;
  logic [31:0]     txd_q, txd_d;
  logic [3:0]      txc_q, txc_d;
  logic            underrun_q, underrun_d;
  logic            bad_start_q, bad_start_d;
  logic            w_start, w_term, take_term, rd_req;

  always_comb begin
    w_start = fifo_rd_data[32] && (fifo_rd_data[7:0] == 8'hFB);
    w_term  = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (fifo_rd_data[32 + i] && (fifo_rd_data[8*i +: 8] == 8'hFD)) begin
        w_term = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ipg_cnt_d   = ipg_cnt_q;
    txd_d       = IDLE_TXD;
    txc_d       = 4'hF;
    underrun_d  = 1'b0;
    bad_start_d = 1'b0;
    take_term   = 1'b0;
    rd_req      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        rd_req = tx_enable && !fifo_empty;
        if (p_q) begin
          if (w_start) begin
            txd_d = fifo_rd_data[31:0];
            txc_d = fifo_rd_data[35:32];
            if (w_term) take_term = 1'b1;
            else        state_d   = ST_DATA;
          end else begin
            bad_start_d = 1'b1;
          end
        end
      end
      ST_DATA: begin
        // Stop reading as soon as the terminate is in hand.
        rd_req = !fifo_empty && !(p_q && w_term);
        if (p_q) begin
          txd_d = fifo_rd_data[31:0];
          txc_d = fifo_rd_data[35:32];
          if (w_term) take_term = 1'b1;
        end else begin
          txd_d      = ERR_TXD;
          txc_d      = 4'hF;
          underrun_d = 1'b1;
          state_d    = ST_DISCARD;
        end
      end
      ST_DISCARD: begin
        rd_req = !fifo_empty && !(p_q && w_term);
        if (p_q && w_term) take_term = 1'b1;
      end
      ST_IPG: begin
        if (ipg_cnt_q == '0) state_d = ST_IDLE;
        else                 ipg_cnt_d = ipg_cnt_q - CW'(1);
      end
      default: state_d = ST_IDLE;
    endcase

    // Terminate cycle counts as the first gap slot (IPG or IDLE), and the
    // read issued from IDLE adds one more, so the counter starts at IPG-2.
    if (take_term) begin
      if (IPG_WORDS == 1) begin
        state_d = ST_IDLE;
      end else begin
        ipg_cnt_d = CW'(IPG_WORDS - 2);
        state_d   = ST_IPG;
      end
    end

    fifo_rd_en = rd_req && rst;
    p_d        = fifo_rd_en && !fifo_empty;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      p_q         <= 1'b0;
      ipg_cnt_q   <= '0;
      txd_q       <= IDLE_TXD;
      txc_q       <= 4'hF;
      underrun_q  <= 1'b0;
      bad_start_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      p_q         <= p_d;
      ipg_cnt_q   <= ipg_cnt_d;
      txd_q       <= txd_d;
      txc_q       <= txc_d;
      underrun_q  <= underrun_d;
      bad_start_q <= bad_start_d;
    end
  end

  assign xgmii_txd     = txd_q;
  assign xgmii_txc     = txc_q;
  assign busy          = (state_q != ST_IDLE);
  assign underrun_err  = underrun_q;
  assign bad_start_err = bad_start_q;

`ifdef XGMII_TX_STATS_EN
  logic [31:0] frame_count_q, frame_count_d;
  logic [15:0] underrun_count_q, underrun_count_d;

  always_comb begin
    frame_count_d    = frame_count_q;
    underrun_count_d = underrun_count_q;
    if (state_q == ST_IDLE && p_q && w_start) frame_count_d = frame_count_q + 32'd1;
    if (underrun_d && underrun_count_q != 16'hFFFF) underrun_count_d = underrun_count_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_count_q    <= '0;
      underrun_count_q <= '0;
    end else begin
      frame_count_q    <= frame_count_d;
      underrun_count_q <= underrun_count_d;
    end
  end

  assign frame_count    = frame_count_q;
  assign underrun_count = underrun_count_q;
`endif

endmodule

// File: tb/tb_xgmii_tx_fifo_reader.sv
// Bench for xgmii_tx_fifo_reader: drives a queue-based FIFO model and
// checks the XGMII stream against a scoreboard of expected frame words.
`timescale 1ns/1ps

module tb_xgmii_tx_fifo_reader;

  localparam int unsigned IPG = 3;
  localparam logic [35:0] IDLE_W = 36'hF_07070707;
  localparam logic [35:0] ERR_W  = 36'hF_FEFEFEFE;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        tx_enable = 1'b1;
  logic        fifo_empty;
  logic        fifo_rd_en;
  logic [35:0] fifo_rd_data;
  logic [31:0] xgmii_txd;
  logic [3:0]  xgmii_txc;
  logic        busy, underrun_err, bad_start_err;
`ifdef XGMII_TX_STATS_EN
  logic [31:0] frame_count;
  logic [15:0] underrun_count;
`endif

  xgmii_tx_fifo_reader #(.IPG_WORDS(IPG)) dut (
    .clk(clk), .rst(rst), .tx_enable(tx_enable), .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data),
    .xgmii_txd(xgmii_txd), .xgmii_txc(xgmii_txc), .busy(busy),
    .underrun_err(underrun_err), .bad_start_err(bad_start_err)
`ifdef XGMII_TX_STATS_EN
    , .frame_count(frame_count), .underrun_count(underrun_count)
`endif
  );

  always #5 clk = ~clk;

  // FIFO model: registered read data, empty flag updated on the clock.
  logic [35:0] fifo_q[$];
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      fifo_q.delete();
      fifo_empty   <= 1'b1;
      fifo_rd_data <= '0;
    end else begin
      if (fifo_rd_en && !fifo_empty) fifo_rd_data <= fifo_q.pop_front();
      fifo_empty <= (fifo_q.size() == 0);
    end
  end

  // Scoreboard state
  logic [35:0] exp_q[$];
  int  n_cmp = 0, n_fail = 0;
  int  cyc = 0;
  bit  chk_en = 0;
  bit  in_frame = 0;
  int  idle_run = 0, gap_seen = -1;
  int  start_cyc = -1, term_cyc = -1;
  int  first_rd_cyc = -1, first_rd_after_term = -1;
  int  ur_seen = 0, bs_seen = 0;
  logic [31:0] start_txd;
  logic [35:0] mon_e, mon_out;

  function automatic bit m_is_term(input logic [35:0] w);
    for (int i = 0; i < 4; i++)
      if (w[32+i] && ((w >> (8*i)) & 36'hFF) == 36'hFD) return 1'b1;
    return 1'b0;
  endfunction

  // Compare process: every enabled cycle the XGMII word is either an idle
  // (only legal outside a frame) or the next expected frame word.
  always @(negedge clk) begin
    cyc++;
    if (chk_en) begin
      n_cmp++;
      mon_out = {xgmii_txc, xgmii_txd};
      if (underrun_err) ur_seen++;
      if (bad_start_err) bs_seen++;
      if (mon_out == IDLE_W) begin
        if (in_frame) begin
          n_fail++;
          $display("FAIL bubble: got idle %h inside frame, expected %h", mon_out, exp_q.size() ? exp_q[0] : 36'h0);
        end
        idle_run++;
      end else if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_word: got %h expected idle %h", mon_out, IDLE_W);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_out !== mon_e) begin
          n_fail++;
          $display("FAIL xgmii_word: got %h expected %h", mon_out, mon_e);
        end
        if (!in_frame) begin
          start_cyc = cyc;
          gap_seen  = idle_run;
          start_txd = xgmii_txd;
        end
        if (m_is_term(mon_e) || mon_e == ERR_W) begin
          in_frame = 0;
          term_cyc = cyc;
          idle_run = 0;
          first_rd_after_term = -1;
        end else begin
          in_frame = 1;
        end
      end
      if (fifo_rd_en) begin
        if (first_rd_cyc < 0) first_rd_cyc = cyc;
        if (first_rd_after_term < 0 && term_cyc >= 0 && !in_frame) first_rd_after_term = cyc;
      end
    end
  end

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic check(input string name, input longint got, input longint exp);
    n_cmp++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic push(input logic [35:0] w, input bit expect_out);
    fifo_q.push_back(w);
    if (expect_out) exp_q.push_back(w);
  endtask

  task automatic wait_term(input string name);
    int old;
    bit hit;
    old = term_cyc;
    hit = 0;
    for (int i = 0; i < 200 && !hit; i++) begin
      tick();
      if (term_cyc != old) hit = 1;
    end
    if (!hit) begin n_cmp++; n_fail++; $display("FAIL %s: got timeout expected terminate", name); end
  endtask

  task automatic wait_start(input string name);
    int old;
    bit hit;
    old = start_cyc;
    hit = 0;
    for (int i = 0; i < 200 && !hit; i++) begin
      tick();
      if (start_cyc != old) hit = 1;
    end
    if (!hit) begin n_cmp++; n_fail++; $display("FAIL %s: got timeout expected start", name); end
  endtask

  task automatic wait_drain(input string name);
    bit done;
    done = 0;
    for (int i = 0; i < 300 && !done; i++) begin
      if (exp_q.size() == 0 && !busy && !in_frame && fifo_empty) done = 1;
      else tick();
    end
    check({name, "_drain"}, done, 1);
    repeat (4) tick();
  endtask

  logic [35:0] F1[4] = '{36'h1_555555FB, 36'h0_D5555555, 36'h0_11223344, 36'hF_070707FD};
  logic [35:0] F2[3] = '{36'h1_AABBCCFB, 36'h0_01020304, 36'h8_FD060708};

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected $finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) tick();
    check("rst_txd", xgmii_txd, 32'h07070707);
    check("rst_txc", xgmii_txc, 4'hF);
    check("rst_busy", busy, 0);
    check("rst_rd_en", fifo_rd_en, 0);
    check("rst_underrun", underrun_err, 0);
    check("rst_bad_start", bad_start_err, 0);
    rst = 1'b1;
    chk_en = 1;

    // Empty FIFO with tx_enable: idles only, no reads
    for (int i = 0; i < 4; i++) begin
      tick();
      check("idle_txd", xgmii_txd, 32'h07070707);
      check("idle_rd_en", fifo_rd_en, 0);
      check("idle_busy", busy, 0);
    end

    // Single frame: latency and busy through the gap
    first_rd_cyc = -1;
    foreach (F1[i]) push(F1[i], 1);
    wait_term("f1_term");
    check("f1_latency", start_cyc - first_rd_cyc, 2);
    check("f1_first_txd", start_txd, 32'h555555FB);
    check("f1_busy_ipg0", busy, 1);
    tick();
    check("f1_busy_ipg1", busy, 1);
    tick();
    check("f1_busy_after_ipg", busy, 0);
    wait_drain("f1");
`ifdef XGMII_TX_STATS_EN
    check("f1_frame_count", frame_count, 1);
`endif

    // Back-to-back frames: exact gap, no reads until the gap is nearly over
    foreach (F1[i]) push(F1[i], 1);
    foreach (F2[i]) push(F2[i], 1);
    wait_term("b2b_term");
    wait_start("b2b_start2");
    check("b2b_gap", gap_seen, IPG);
    check("b2b_first_rd_after_term", first_rd_after_term - term_cyc, IPG - 1);
    check("b2b_start2_txd", start_txd, 32'hAABBCCFB);
    wait_drain("b2b");
`ifdef XGMII_TX_STATS_EN
    check("b2b_frame_count", frame_count, 3);
`endif

    // Underrun after start + one data word
    ur_seen = 0;
    push(36'h1_555555FB, 1);
    push(36'h0_12345678, 1);
    exp_q.push_back(ERR_W);
    repeat (10) tick();
    check("ur_busy_discard", busy, 1);
    push(36'h0_9ABCDEF0, 0);
    push(36'h0_0BADF00D, 0);
    push(36'hF_070707FD, 0);
    wait_drain("ur");
    check("ur_pulses", ur_seen, 1);
    foreach (F2[i]) push(F2[i], 1);
    wait_drain("ur_next");
    check("ur_next_txd", start_txd, 32'hAABBCCFB);
`ifdef XGMII_TX_STATS_EN
    check("ur_underrun_count", underrun_count, 1);
    check("ur_frame_count", frame_count, 5);
`endif

    // Bad start word dropped in IDLE, then a good frame
    bs_seen = 0;
    push(36'h0_DEADBEEF, 0);
    foreach (F1[i]) push(F1[i], 1);
    wait_drain("bs");
    check("bs_pulses", bs_seen, 1);
    check("bs_next_txd", start_txd, 32'h555555FB);

    // tx_enable low holds the frame in the FIFO
    tx_enable = 1'b0;
    first_rd_cyc = -1;
    foreach (F2[i]) push(F2[i], 1);
    repeat (8) tick();
    check("txen_no_read", first_rd_cyc, -1);
    check("txen_busy", busy, 0);
    tx_enable = 1'b1;
    wait_drain("txen");

    // Reset asserted mid-frame
    push(36'h1_555555FB, 1);
    for (int i = 1; i <= 6; i++) push(36'h0_00000000 | 36'(i), 1);
    push(36'hF_070707FD, 1);
    wait_start("mid_start");
    repeat (2) tick();
    chk_en = 0;
    rst = 1'b0;
    #1;
    check("midrst_txd", xgmii_txd, 32'h07070707);
    check("midrst_txc", xgmii_txc, 4'hF);
    check("midrst_busy", busy, 0);
    check("midrst_rd_en", fifo_rd_en, 0);
`ifdef XGMII_TX_STATS_EN
    check("midrst_frame_count", frame_count, 0);
    check("midrst_underrun_count", underrun_count, 0);
`endif
    exp_q.delete();
    in_frame = 0;
    idle_run = 0;
    repeat (3) tick();
    rst = 1'b1;
    chk_en = 1;
    repeat (3) tick();
    check("post_rst_txd", xgmii_txd, 32'h07070707);
    check("post_rst_busy", busy, 0);
    foreach (F1[i]) push(F1[i], 1);
    wait_drain("post_rst");
    check("post_rst_txd_start", start_txd, 32'h555555FB);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/xgmii_tx_fifo_reader.md
Name: xgmii_tx_fifo_reader

Overview:
- Drains the 36-bit TX word FIFO (sync_fifo, registered read data) and drives the 32-bit XGMII TX interface toward the PCS.
- Inserts idles when no frame is in flight, aligns output to frame start and enforces minimum inter-packet gap.
- Detects FIFO underrun mid-frame and aborts the frame with error codes.
- FIFO word format: [35:32] = txc lanes 3..0, [31:0] = txd; lane 0 = bits [7:0] / bit 32.

Parameters:
- IPG_WORDS, 3: minimum idle words on XGMII between a terminate word and the next start word. Legal range is 1 or more.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- tx_enable  in  1  permits starting a new frame; sampled only in IDLE
- fifo_empty  in  1  FIFO empty flag
- fifo_rd_en  out  1  FIFO read request; combinational
- fifo_rd_data  in  36  FIFO read data; valid the cycle after an accepted read
- xgmii_txd  out  32  XGMII data; registered
- xgmii_txc  out  4  XGMII control; registered
- busy  out  1  state != IDLE
- underrun_err  out  1  one-cycle pulse on underrun abort
- bad_start_err  out  1  one-cycle pulse when a non-start word is dropped in IDLE

Behaviour:
- Definitions:
  - p: register set when fifo_rd_en && !fifo_empty in the previous cycle; w = fifo_rd_data is meaningful only when p=1.
  - is_start(w): w[32]=1 && w[7:0]=0xFB.
  - is_term(w): any lane i with w[32+i]=1 && byte i = 0xFD.
  - IDLE word: txd 0x07070707, txc 0xF. ERROR word: txd 0xFEFEFEFE, txc 0xF.
- Reset (async, rst=0): state IDLE, p=0, txd/txc = IDLE word, busy/err pulses 0, IPG counter 0; fifo_rd_en=0 while in reset.
- Latency: an accepted read in cycle n makes w visible at n+1; XGMII shows it at n+2.
- Default output every cycle is the IDLE word unless stated below.
- IDLE state:
  - fifo_rd_en = tx_enable && !fifo_empty.
  - If p && is_start(w): emit w; if is_term(w) too, apply terminate rule; else go to DATA.
  - If p && !is_start(w): drop w, pulse bad_start_err, stay in IDLE.
  - A word already read when tx_enable falls is still processed.
- DATA state:
  - fifo_rd_en = !fifo_empty && !(p && is_term(w)), so no word is read past the terminate.
  - p: emit w; if is_term(w), apply terminate rule.
  - !p (underrun): emit the ERROR word, pulse underrun_err, go to DISCARD.
  - tx_enable is ignored; the frame always completes.
- DISCARD state:
  - fifo_rd_en has the same rule as DATA; read words are dropped and IDLE words are emitted.
  - On p && is_term(w), apply terminate rule; the terminate word itself is not emitted.
- Terminate rule:
  - If IPG_WORDS == 1: go to IDLE.
  - Else: load counter = IPG_WORDS-2 and go to IPG.
- IPG state:
  - fifo_rd_en=0; emit IDLE.
  - counter==0 -> IDLE; else decrement.
- Resulting gap: exactly IPG_WORDS IDLE words between terminate and next start when the FIFO holds the next frame.
- Back-to-back data: a full FIFO streams one word per clock with no bubbles.
- Reset mid-frame: immediate return to the reset state; no terminate is emitted. The FIFO is reset by the same rst.

Optional Feature:
- Macro: XGMII_TX_STATS_EN.
- Defined: adds outputs frame_count (32-bit, wrapping) and underrun_count (16-bit, saturating at 0xFFFF), both reset to 0.
  - frame_count increments on each emitted start word.
  - underrun_count increments on each underrun_err pulse.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset release, FIFO empty, tx_enable=1 -> txd 0x07070707 / txc 0xF every cycle; fifo_rd_en=0; busy=0.
- Frame preloaded into FIFO: {0x1,0x555555FB}, {0x0,0xD5555555}, {0x0,0x11223344}, {0xF,0x070707FD} -> same 4 words on XGMII on consecutive cycles; first word 2 cycles after first fifo_rd_en; busy high through IPG.
- Two frames back-to-back in FIFO, IPG_WORDS=3 -> exactly 3 IDLE words between terminate and second start; no fifo_rd_en issued after the first terminate until IPG ends.
- FIFO empties after start + 1 data word, then 2 more words plus {0xF,0x0707FDxx-style terminate 0x070707FD} arrive -> ERROR word 0xFEFEFEFE/0xF emitted once, underrun_err pulses once, late words dropped, IDLE output, next frame starts normally.
- FIFO head word {0x0,0xDEADBEEF} in IDLE -> word dropped, bad_start_err pulses once, no XGMII output change; a following start frame is transmitted correctly.
- rst asserted while in DATA -> txd/txc = IDLE word and busy=0 asynchronously; with XGMII_TX_STATS_EN, frame_count=1 after frame 1 and underrun_count increments by 1 per underrun.
